wb_modport: RTL and testbench

WB_MODPORT -- requirements
Module: wb_modport

---
 rtl/wb_modport_pkg.sv | 32 +++
 rtl/wb_modport_arb.sv | 38 +++
 rtl/wb_modport.sv | 204 ++++++++++++++++++++
 tb/tb_wb_modport.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_modport_pkg.sv
// Shared types and constants for the wb_modport shared-bus interconnect.
package wb_modport_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 32;
  localparam int SW_DEF    = 4;
  localparam int NUM_M     = 4;
  localparam int NUM_S     = 4;
  localparam int TMO_LIMIT = 15;
  localparam int TMO_W     = 4;

  typedef enum logic [2:0] {
    OWN_M0   = 3'd0,
    OWN_M1   = 3'd1,
    OWN_M2   = 3'd2,
    OWN_M3   = 3'd3,
    OWN_NONE = 3'd4
  } owner_e;

  // First requester at or after ptr, wrapping 3->0; the downward loop lets the closest one win.
  function automatic owner_e rr_pick(input logic [NUM_M-1:0] req, input logic [1:0] ptr);
    owner_e     pick;
    logic [1:0] idx;
    pick = OWN_NONE;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = owner_e'({1'b0, idx});
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_modport_arb.sv
// Round-robin bus owner register: re-arbitrates only when the bus is free or the owner drops cyc.
module wb_modport_arb
  import wb_modport_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req_i,
  output owner_e           owner_o
);

  owner_e     owner_q, owner_d;
  logic [2:0] owner_bits;
  logic [1:0] ptr_q, ptr_d;

  assign owner_bits = owner_q;

  always_comb begin
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (owner_q == OWN_NONE || !req_i[owner_bits[1:0]]) begin
      owner_d = rr_pick(req_i, ptr_q);
      if (owner_d != OWN_NONE) ptr_d = owner_d[1:0] + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      ptr_q   <= '0;
    end else begin
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/wb_modport.sv
// Four-master / four-slave shared Wishbone bus with address-based slave decode.
// Optional watchdog on stalled transfers: define WB_MODPORT_TIMEOUT_EN.
module wb_modport
  import wb_modport_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] m0_data_i,
  output logic [DW-1:0] m0_data_o,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  input  logic [DW-1:0] m1_data_i,
  output logic [DW-1:0] m1_data_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  input  logic [DW-1:0] m2_data_i,
  output logic [DW-1:0] m2_data_o,
  input  logic [AW-1:0] m2_addr_i,
  input  logic [SW-1:0] m2_sel_i,
  input  logic          m2_we_i,
  input  logic          m2_cyc_i,
  input  logic          m2_stb_i,
  output logic          m2_ack_o,
  output logic          m2_err_o,
  output logic          m2_rty_o,
  input  logic [DW-1:0] m3_data_i,
  output logic [DW-1:0] m3_data_o,
  input  logic [AW-1:0] m3_addr_i,
  input  logic [SW-1:0] m3_sel_i,
  input  logic          m3_we_i,
  input  logic          m3_cyc_i,
  input  logic          m3_stb_i,
  output logic          m3_ack_o,
  output logic          m3_err_o,
  output logic          m3_rty_o,
  input  logic [DW-1:0] s0_data_i,
  output logic [DW-1:0] s0_data_o,
  output logic [AW-1:0] s0_addr_o,
  output logic [SW-1:0] s0_sel_o,
  output logic          s0_we_o,
  output logic          s0_cyc_o,
  output logic          s0_stb_o,
  input  logic          s0_ack_i,
  input  logic          s0_err_i,
  input  logic          s0_rty_i,
  input  logic [DW-1:0] s1_data_i,
  output logic [DW-1:0] s1_data_o,
  output logic [AW-1:0] s1_addr_o,
  output logic [SW-1:0] s1_sel_o,
  output logic          s1_we_o,
  output logic          s1_cyc_o,
  output logic          s1_stb_o,
  input  logic          s1_ack_i,
  input  logic          s1_err_i,
  input  logic          s1_rty_i,
  input  logic [DW-1:0] s2_data_i,
  output logic [DW-1:0] s2_data_o,
  output logic [AW-1:0] s2_addr_o,
  output logic [SW-1:0] s2_sel_o,
  output logic          s2_we_o,
  output logic          s2_cyc_o,
  output logic          s2_stb_o,
  input  logic          s2_ack_i,
  input  logic          s2_err_i,
  input  logic          s2_rty_i,
  input  logic [DW-1:0] s3_data_i,
  output logic [DW-1:0] s3_data_o,
  output logic [AW-1:0] s3_addr_o,
  output logic [SW-1:0] s3_sel_o,
  output logic          s3_we_o,
  output logic          s3_cyc_o,
  output logic          s3_stb_o,
  input  logic          s3_ack_i,
  input  logic          s3_err_i,
  input  logic          s3_rty_i
);

  logic [DW-1:0]    m_wdat [NUM_M];
  logic [AW-1:0]    m_adr  [NUM_M];
  logic [SW-1:0]    m_sel  [NUM_M];
  logic [NUM_M-1:0] m_we, m_cyc, m_stb;
  logic [DW-1:0]    s_rdat [NUM_S];
  logic [NUM_S-1:0] s_ack, s_err, s_rty;

  assign m_wdat = '{m0_data_i, m1_data_i, m2_data_i, m3_data_i};
  assign m_adr  = '{m0_addr_i, m1_addr_i, m2_addr_i, m3_addr_i};
  assign m_sel  = '{m0_sel_i, m1_sel_i, m2_sel_i, m3_sel_i};
  assign m_we   = {m3_we_i, m2_we_i, m1_we_i, m0_we_i};
  assign m_cyc  = {m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign m_stb  = {m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};
  assign s_rdat = '{s0_data_i, s1_data_i, s2_data_i, s3_data_i};
  assign s_ack  = {s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};
  assign s_err  = {s3_err_i, s2_err_i, s1_err_i, s0_err_i};
  assign s_rty  = {s3_rty_i, s2_rty_i, s1_rty_i, s0_rty_i};

  owner_e     owner;
  logic [2:0] own_bits;
  logic       own_vld;
  logic [1:0] oidx, sidx;
  logic       tmo_hit;

  wb_modport_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (m_cyc),
    .owner_o(owner)
  );

  // Gating with rst kills an in-flight transfer in the very cycle reset is asserted.
  assign own_bits = owner;
  assign own_vld  = rst && (owner != OWN_NONE);
  assign oidx     = own_bits[1:0];
  assign sidx     = m_adr[oidx][AW-1:AW-2];

`ifdef WB_MODPORT_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             xfer_act, slv_resp;

  assign xfer_act  = own_vld && m_cyc[oidx] && m_stb[oidx];
  assign slv_resp  = s_ack[sidx] | s_err[sidx] | s_rty[sidx];
  assign tmo_hit   = xfer_act && (tmo_cnt_q == TMO_W'(TMO_LIMIT));
  assign tmo_cnt_d = (!xfer_act || slv_resp || tmo_hit) ? '0 : tmo_cnt_q + TMO_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) tmo_cnt_q <= '0;
    else      tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  logic [AW-1:0]    bus_adr;
  logic [DW-1:0]    bus_dat, rdat;
  logic [SW-1:0]    bus_sel;
  logic             bus_we;
  logic [NUM_S-1:0] s_cyc, s_stb;
  logic [NUM_M-1:0] m_ack, m_err, m_rty;

  always_comb begin
    bus_adr = '0;
    bus_dat = '0;
    bus_sel = '0;
    bus_we  = 1'b0;
    rdat    = '0;
    s_cyc   = '0;
    s_stb   = '0;
    m_ack   = '0;
    m_err   = '0;
    m_rty   = '0;
    if (own_vld) begin
      bus_adr     = m_adr[oidx];
      bus_dat     = m_wdat[oidx];
      bus_sel     = m_sel[oidx];
      bus_we      = m_we[oidx];
      rdat        = s_rdat[sidx];
      s_cyc[sidx] = m_cyc[oidx];
      s_stb[sidx] = m_stb[oidx] & ~tmo_hit;
      m_ack[oidx] = s_ack[sidx] & ~tmo_hit;
      m_err[oidx] = s_err[sidx] | tmo_hit;
      m_rty[oidx] = s_rty[sidx] & ~tmo_hit;
    end
  end

  assign {m3_ack_o, m2_ack_o, m1_ack_o, m0_ack_o} = m_ack;
  assign {m3_err_o, m2_err_o, m1_err_o, m0_err_o} = m_err;
  assign {m3_rty_o, m2_rty_o, m1_rty_o, m0_rty_o} = m_rty;
  assign m0_data_o = rdat;
  assign m1_data_o = rdat;
  assign m2_data_o = rdat;
  assign m3_data_o = rdat;

  assign {s3_cyc_o, s2_cyc_o, s1_cyc_o, s0_cyc_o} = s_cyc;
  assign {s3_stb_o, s2_stb_o, s1_stb_o, s0_stb_o} = s_stb;
  assign {s3_we_o, s2_we_o, s1_we_o, s0_we_o}     = {NUM_S{bus_we}};
  assign s0_addr_o = bus_adr;
  assign s1_addr_o = bus_adr;
  assign s2_addr_o = bus_adr;
  assign s3_addr_o = bus_adr;
  assign s0_data_o = bus_dat;
  assign s1_data_o = bus_dat;
  assign s2_data_o = bus_dat;
  assign s3_data_o = bus_dat;
  assign s0_sel_o  = bus_sel;
  assign s1_sel_o  = bus_sel;
  assign s2_sel_o  = bus_sel;
  assign s3_sel_o  = bus_sel;

endmodule

// File: tb/tb_wb_modport.sv
// Directed and randomized checks of wb_modport against a cycle-level behavioural bus model.
module tb_wb_modport;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_data_i [4];
  logic [31:0] m_data_o [4];
  logic [31:0] m_addr_i [4];
  logic [3:0]  m_sel_i  [4];
  logic [3:0]  m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o, m_rty_o;
  logic [31:0] s_data_i [4];
  logic [31:0] s_data_o [4];
  logic [31:0] s_addr_o [4];
  logic [3:0]  s_sel_o  [4];
  logic [3:0]  s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;

  wb_modport dut (
    .clk(clk), .rst(rst),
    .m0_data_i(m_data_i[0]), .m0_data_o(m_data_o[0]), .m0_addr_i(m_addr_i[0]), .m0_sel_i(m_sel_i[0]),
    .m0_we_i(m_we_i[0]), .m0_cyc_i(m_cyc_i[0]), .m0_stb_i(m_stb_i[0]),
    .m0_ack_o(m_ack_o[0]), .m0_err_o(m_err_o[0]), .m0_rty_o(m_rty_o[0]),
    .m1_data_i(m_data_i[1]), .m1_data_o(m_data_o[1]), .m1_addr_i(m_addr_i[1]), .m1_sel_i(m_sel_i[1]),
    .m1_we_i(m_we_i[1]), .m1_cyc_i(m_cyc_i[1]), .m1_stb_i(m_stb_i[1]),
    .m1_ack_o(m_ack_o[1]), .m1_err_o(m_err_o[1]), .m1_rty_o(m_rty_o[1]),
    .m2_data_i(m_data_i[2]), .m2_data_o(m_data_o[2]), .m2_addr_i(m_addr_i[2]), .m2_sel_i(m_sel_i[2]),
    .m2_we_i(m_we_i[2]), .m2_cyc_i(m_cyc_i[2]), .m2_stb_i(m_stb_i[2]),
    .m2_ack_o(m_ack_o[2]), .m2_err_o(m_err_o[2]), .m2_rty_o(m_rty_o[2]),
    .m3_data_i(m_data_i[3]), .m3_data_o(m_data_o[3]), .m3_addr_i(m_addr_i[3]), .m3_sel_i(m_sel_i[3]),
    .m3_we_i(m_we_i[3]), .m3_cyc_i(m_cyc_i[3]), .m3_stb_i(m_stb_i[3]),
    .m3_ack_o(m_ack_o[3]), .m3_err_o(m_err_o[3]), .m3_rty_o(m_rty_o[3]),
    .s0_data_i(s_data_i[0]), .s0_data_o(s_data_o[0]), .s0_addr_o(s_addr_o[0]), .s0_sel_o(s_sel_o[0]),
    .s0_we_o(s_we_o[0]), .s0_cyc_o(s_cyc_o[0]), .s0_stb_o(s_stb_o[0]),
    .s0_ack_i(s_ack_i[0]), .s0_err_i(s_err_i[0]), .s0_rty_i(s_rty_i[0]),
    .s1_data_i(s_data_i[1]), .s1_data_o(s_data_o[1]), .s1_addr_o(s_addr_o[1]), .s1_sel_o(s_sel_o[1]),
    .s1_we_o(s_we_o[1]), .s1_cyc_o(s_cyc_o[1]), .s1_stb_o(s_stb_o[1]),
    .s1_ack_i(s_ack_i[1]), .s1_err_i(s_err_i[1]), .s1_rty_i(s_rty_i[1]),
    .s2_data_i(s_data_i[2]), .s2_data_o(s_data_o[2]), .s2_addr_o(s_addr_o[2]), .s2_sel_o(s_sel_o[2]),
    .s2_we_o(s_we_o[2]), .s2_cyc_o(s_cyc_o[2]), .s2_stb_o(s_stb_o[2]),
    .s2_ack_i(s_ack_i[2]), .s2_err_i(s_err_i[2]), .s2_rty_i(s_rty_i[2]),
    .s3_data_i(s_data_i[3]), .s3_data_o(s_data_o[3]), .s3_addr_o(s_addr_o[3]), .s3_sel_o(s_sel_o[3]),
    .s3_we_o(s_we_o[3]), .s3_cyc_o(s_cyc_o[3]), .s3_stb_o(s_stb_o[3]),
    .s3_ack_i(s_ack_i[3]), .s3_err_i(s_err_i[3]), .s3_rty_i(s_rty_i[3])
  );

`ifdef WB_MODPORT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = none), round-robin start point, stalled-strobe cycle count.
  int mo_own = -1;
  int mo_ptr = 0;
  int mo_wait = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int slave_of(input int m);
    return int'(m_addr_i[m][31:30]);
  endfunction

  function automatic bit mo_timeout();
    if (!TMO || !rst || mo_own < 0) return 1'b0;
    return m_cyc_i[mo_own] && m_stb_i[mo_own] && (mo_wait == 15);
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] e_adr, e_dat, e_rd;
    logic [3:0]  e_sel, e_scyc, e_sstb, e_ack, e_err, e_rty;
    logic        e_we;
    int          s;
    bit          t;
    e_adr = '0; e_dat = '0; e_rd = '0; e_sel = '0; e_we = 1'b0;
    e_scyc = '0; e_sstb = '0; e_ack = '0; e_err = '0; e_rty = '0;
    if (rst && mo_own >= 0) begin
      s = slave_of(mo_own);
      t = mo_timeout();
      e_adr = m_addr_i[mo_own];
      e_dat = m_data_i[mo_own];
      e_sel = m_sel_i[mo_own];
      e_we  = m_we_i[mo_own];
      e_rd  = s_data_i[s];
      e_scyc[s] = m_cyc_i[mo_own];
      e_sstb[s] = m_stb_i[mo_own] && !t;
      e_ack[mo_own] = s_ack_i[s] && !t;
      e_err[mo_own] = s_err_i[s] || t;
      e_rty[mo_own] = s_rty_i[s] && !t;
    end
    chk({tag, "/s_cyc"}, 32'(s_cyc_o), 32'(e_scyc));
    chk({tag, "/s_stb"}, 32'(s_stb_o), 32'(e_sstb));
    chk({tag, "/s_we"}, 32'(s_we_o), 32'({4{e_we}}));
    chk({tag, "/m_ack"}, 32'(m_ack_o), 32'(e_ack));
    chk({tag, "/m_err"}, 32'(m_err_o), 32'(e_err));
    chk({tag, "/m_rty"}, 32'(m_rty_o), 32'(e_rty));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s/m_data_o%0d", tag, i), m_data_o[i], e_rd);
      chk($sformatf("%s/s_addr_o%0d", tag, i), s_addr_o[i], e_adr);
      chk($sformatf("%s/s_data_o%0d", tag, i), s_data_o[i], e_dat);
      chk($sformatf("%s/s_sel_o%0d", tag, i), 32'(s_sel_o[i]), 32'(e_sel));
    end
  endtask

  // Advance the model by one edge using the inputs present just before it.
  task automatic tick();
    int n_own, n_ptr, n_wait, s;
    bit act, resp, t;
    if (!rst) begin
      n_own = -1; n_ptr = 0; n_wait = 0;
    end else begin
      n_own = mo_own; n_ptr = mo_ptr;
      t = mo_timeout();
      act = 1'b0; resp = 1'b0;
      if (mo_own >= 0) begin
        s = slave_of(mo_own);
        act = m_cyc_i[mo_own] && m_stb_i[mo_own];
        resp = s_ack_i[s] || s_err_i[s] || s_rty_i[s];
      end
      n_wait = (TMO && act && !resp && !t) ? mo_wait + 1 : 0;
      if (mo_own < 0 || !m_cyc_i[mo_own]) begin
        n_own = -1;
        for (int k = 0; k < 4; k++)
          if (n_own < 0 && m_cyc_i[(mo_ptr + k) % 4]) n_own = (mo_ptr + k) % 4;
        if (n_own >= 0) n_ptr = (n_own + 1) % 4;
      end
    end
    @(posedge clk);
    mo_own = n_own; mo_ptr = n_ptr; mo_wait = n_wait;
    #1;
  endtask

  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    tick();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      m_data_i[i] = '0; m_addr_i[i] = '0; m_sel_i[i] = '0; s_data_i[i] = '0;
    end
    m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
  endtask

  task automatic idle(input int n);
    clear_all();
    repeat (n) step("idle");
  endtask

  int order[$];
  int ack_at[$];
  int first_err;

  initial begin
    clear_all();

    // Reset with every master requesting: nothing may leak out.
    rst = 1'b0;
    m_cyc_i = 4'hF; m_stb_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
      chk("rst_m_ack", 32'(m_ack_o), 32'h0);
      step("reset");
    end
    rst = 1'b1;
    step("release");
    #1;
    chk("grant_m0_after_release", 32'(s_cyc_o), 32'h1);

    // m1 write to slave 1.
    idle(2);
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b1;
    m_addr_i[1] = 32'h4000_0010; m_data_i[1] = 32'hDEAD_BEEF; m_sel_i[1] = 4'hF;
    step("m1_req");
    #1;
    chk("m1_s_cyc", 32'(s_cyc_o), 32'h2);
    chk("m1_s_stb", 32'(s_stb_o), 32'h2);
    chk("m1_s1_we", 32'(s_we_o[1]), 32'h1);
    chk("m1_s1_addr", s_addr_o[1], 32'h4000_0010);
    chk("m1_s1_data", s_data_o[1], 32'hDEAD_BEEF);
    s_ack_i[1] = 1'b1;
    #1;
    chk("m1_ack_same_cycle", 32'(m_ack_o), 32'h2);
    step("m1_ack");

    // m2 read from slave 3.
    idle(2);
    m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_addr_i[2] = 32'hC000_0004;
    s_data_i[3] = 32'h1234_5678;
    step("m2_req");
    s_ack_i[3] = 1'b1;
    #1;
    chk("m2_rdata", m_data_o[2], 32'h1234_5678);
    chk("m2_ack_only", 32'(m_ack_o), 32'h4);
    step("m2_ack");

    // All four hold cyc from release and drop after one acked transfer.
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_addr_i[i] = 32'(i) << 30;
    m_cyc_i = 4'hF; m_stb_i = 4'hF;
    step("rr_reset");
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_ack_i = '0;
      if (mo_own >= 0 && m_cyc_i[mo_own] && m_stb_i[mo_own]) s_ack_i[slave_of(mo_own)] = 1'b1;
      #1;
      for (int i = 0; i < 4; i++)
        if (m_ack_o[i] === 1'b1) begin
          order.push_back(i);
          ack_at.push_back(c);
        end
      step("rr");
      for (int i = 0; i < 4; i++)
        if (ack_at.size() > 0 && ack_at[ack_at.size()-1] == c && order[order.size()-1] == i) begin
          m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0;
        end
    end
    chk("rr_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) begin
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(ack_at[i] - ack_at[i-1]), 32'd2);
    end

    // Retry keeps ownership.
    idle(2);
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_addr_i[0] = 32'h8000_0000;
    step("rty_req");
    s_rty_i[2] = 1'b1;
    #1;
    chk("rty_o", 32'(m_rty_o), 32'h1);
    step("rty1");
    #1;
    chk("rty_keeps_bus", 32'(s_cyc_o), 32'h4);
    step("rty2");
    s_rty_i[2] = 1'b0; s_ack_i[2] = 1'b1;
    step("rty_ack");

    // Stalled slave: watchdog fires on the 16th strobe cycle only when enabled.
    idle(2);
    m_cyc_i[3] = 1'b1; m_stb_i[3] = 1'b1; m_addr_i[3] = 32'h8000_0000;
    step("tmo_req");
    first_err = -1;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (first_err < 0 && m_err_o[3] === 1'b1) first_err = n;
      step("tmo");
    end
    chk("tmo_first_err_cycle", 32'(first_err), TMO ? 32'd16 : 32'hFFFF_FFFF);

    // Randomized traffic including occasional mid-transfer reset.
    idle(2);
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) m_cyc_i[i] = ~m_cyc_i[i];
        m_stb_i[i] = m_cyc_i[i] & ($urandom_range(0, 3) != 0);
        m_we_i[i] = 1'($urandom());
        m_addr_i[i] = $urandom();
        m_data_i[i] = $urandom();
        m_sel_i[i] = 4'($urandom());
        s_data_i[i] = $urandom();
        s_ack_i[i] = ($urandom_range(0, 3) == 0);
        s_err_i[i] = ($urandom_range(0, 15) == 0);
        s_rty_i[i] = ($urandom_range(0, 15) == 0);
      end
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
